// File: rtl/cpu_icache_pkg.sv
// Shared CPU package for the instruction cache: FSM state encoding,
// address-field width constants and the default geometry.
package cpu_icache_pkg;

  // Default geometry
  localparam int DEF_NUM_LINES      = 4;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_ADDR_WIDTH     = 32;

  // Address-field widths (byte offset is fixed; the rest follow the geometry)
  localparam int BYTE_OFF_W         = 2;
  localparam int WORD_W             = 32;
  localparam int DEF_WORD_OFF_W     = $clog2(DEF_WORDS_PER_LINE);
  localparam int DEF_INDEX_W        = $clog2(DEF_NUM_LINES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2,
    RESPOND  = 2'd3
  } icache_state_e;

endpackage

// File: rtl/cpu_icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Valid bits are reset and cleared by flush; tag and data are not reset.
module cpu_icache_array
  import cpu_icache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int TAG_W          = 26,
  localparam int IDX_W         = $clog2(NUM_LINES),
  localparam int OFF_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              data_we_i,
  input  logic              tag_we_i,
  input  logic              set_valid_i,
  input  logic [IDX_W-1:0]  wr_index_i,
  input  logic [OFF_W-1:0]  wr_offset_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [IDX_W-1:0]  rd_index_i,
  input  logic [OFF_W-1:0]  rd_offset_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [WORD_W-1:0] rd_word_o
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [WORD_W-1:0]    data_q [NUM_LINES*WORDS_PER_LINE];

  // Valid bits: flush clears every line and takes priority over a set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (set_valid_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data storage writes (no reset on the arrays)
  always_ff @(posedge clk_i) begin
    if (data_we_i) begin
      data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
    end
    if (tag_we_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_word_o  = data_q[{rd_index_i, rd_offset_i}];

endmodule

// File: rtl/cpu_icache.sv
// Direct-mapped instruction cache with single-outstanding line refill.
// Optional build macro ICACHE_PERF_EN adds perf_hits_o / perf_misses_o.
module cpu_icache
  import cpu_icache_pkg::*;
#(
  parameter int NUM_LINES      = DEF_NUM_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  output logic                  rsp_valid_o,
  output logic [WORD_W-1:0]     rsp_word_o,
  input  logic                  flush_i,
  output logic                  mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_req_ready_i,
  input  logic                  mem_rsp_valid_i,
  input  logic [WORD_W-1:0]     mem_rsp_data_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           perf_hits_o,
  output logic [31:0]           perf_misses_o
`endif
);

  localparam int OFF_W    = $clog2(WORDS_PER_LINE);
  localparam int IDX_W    = $clog2(NUM_LINES);
  localparam int LINE_LSB = BYTE_OFF_W + OFF_W;
  localparam int TAG_LSB  = LINE_LSB + IDX_W;
  localparam int TAG_W    = ADDR_WIDTH - TAG_LSB;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(TAG_W + IDX_W){1'b1}}, {(LINE_LSB){1'b0}}};
  localparam logic [OFF_W-1:0]      BEAT_LAST = OFF_W'(WORDS_PER_LINE - 1);

  icache_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [OFF_W-1:0]      beat_q, beat_d;
  logic                  flushed_q, flushed_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0]     rsp_word_q, rsp_word_d;

  logic                  in_idle, refill_beat, refill_last, respond;
  logic                  accept, hit, miss, set_valid;
  logic [OFF_W-1:0]      req_off, rd_offset;
  logic [IDX_W-1:0]      req_idx, lat_idx, rd_index;
  logic [TAG_W-1:0]      req_tag, lat_tag, rd_tag;
  logic                  rd_valid;
  logic [WORD_W-1:0]     rd_word;

  assign req_off = req_addr_i[LINE_LSB-1:BYTE_OFF_W];
  assign req_idx = req_addr_i[TAG_LSB-1:LINE_LSB];
  assign req_tag = req_addr_i[ADDR_WIDTH-1:TAG_LSB];
  assign lat_idx = line_addr_q[TAG_LSB-1:LINE_LSB];
  assign lat_tag = line_addr_q[ADDR_WIDTH-1:TAG_LSB];

  // In IDLE the array is looked up with the incoming address, otherwise with the latched miss
  assign rd_index  = in_idle ? req_idx : lat_idx;
  assign rd_offset = in_idle ? req_off : off_q;

  assign accept    = req_valid_i & req_ready_o;
  assign hit       = accept & rd_valid & (rd_tag == req_tag);
  assign miss      = accept & ~hit;
  assign set_valid = refill_last & ~flushed_q & ~flush_i;

  cpu_icache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .data_we_i   (refill_beat),
    .tag_we_i    (refill_last),
    .set_valid_i (set_valid),
    .wr_index_i  (lat_idx),
    .wr_offset_i (beat_q),
    .wr_data_i   (mem_rsp_data_i),
    .wr_tag_i    (lat_tag),
    .rd_index_i  (rd_index),
    .rd_offset_i (rd_offset),
    .rd_valid_o  (rd_valid),
    .rd_tag_o    (rd_tag),
    .rd_word_o   (rd_word)
  );

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = miss ? MISS_REQ : IDLE;
      MISS_REQ: state_d = mem_req_ready_i ? REFILL : MISS_REQ;
      REFILL:   state_d = refill_last ? RESPOND : REFILL;
      RESPOND:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs and state-qualified strobes
  always_comb begin
    in_idle         = (state_q == IDLE);
    req_ready_o     = in_idle & ~flush_i;
    mem_req_valid_o = (state_q == MISS_REQ);
    refill_beat     = (state_q == REFILL) & mem_rsp_valid_i;
    refill_last     = refill_beat & (beat_q == BEAT_LAST);
    respond         = (state_q == RESPOND);
  end

  // Datapath next-state: miss latch, beat counter, flush-during-refill marker, response
  always_comb begin
    line_addr_d = line_addr_q;
    off_d       = off_q;
    beat_d      = beat_q;
    flushed_d   = flushed_q | (flush_i & ((state_q == MISS_REQ) | (state_q == REFILL)));
    if (miss) begin
      line_addr_d = req_addr_i & LINE_MASK;
      off_d       = req_off;
      beat_d      = '0;
      flushed_d   = 1'b0;
    end else if (refill_beat) begin
      beat_d      = beat_q + OFF_W'(1);
    end else begin
      beat_d      = beat_q;
    end
    rsp_valid_d = hit | respond;
    rsp_word_d  = (hit | respond) ? rd_word : rsp_word_q;
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_addr_q <= '0;
      off_q       <= '0;
      beat_q      <= '0;
      flushed_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_word_q  <= '0;
    end else begin
      line_addr_q <= line_addr_d;
      off_q       <= off_d;
      beat_q      <= beat_d;
      flushed_q   <= flushed_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_word_q  <= rsp_word_d;
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_word_o     = rsp_word_q;
  assign mem_req_addr_o = line_addr_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hits_q, perf_misses_q;

  // Wrapping hit/miss counters over accepted requests
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_hits_q   <= 32'd0;
      perf_misses_q <= 32'd0;
    end else begin
      perf_hits_q   <= perf_hits_q + {31'd0, hit};
      perf_misses_q <= perf_misses_q + {31'd0, miss};
    end
  end

  assign perf_hits_o   = perf_hits_q;
  assign perf_misses_o = perf_misses_q;
`endif

endmodule
